// File: rtl/cache_da_mst.sv
// cache_da_mst: cache debug-access sweep initiator issuing single-beat OURS ring reads/writes.
// Optional response watchdog enabled by defining CACHE_DA_MST_TIMEOUT_EN.
package oursring_pkg;
    localparam int RING_ADDR_W = 40;
    localparam int RING_DATA_W = 64;
    localparam int RING_TID_W  = 8;

    typedef struct packed {
        logic [RING_TID_W-1:0]  arid;
        logic [RING_ADDR_W-1:0] araddr;
        logic [7:0]             arlen;
        logic [2:0]             arsize;
        logic [1:0]             arburst;
    } oursring_req_if_ar_t;

    typedef struct packed {
        logic [RING_TID_W-1:0]  awid;
        logic [RING_ADDR_W-1:0] awaddr;
        logic [7:0]             awlen;
        logic [2:0]             awsize;
        logic [1:0]             awburst;
    } oursring_req_if_aw_t;

    typedef struct packed {
        logic [RING_DATA_W-1:0]   wdata;
        logic [RING_DATA_W/8-1:0] wstrb;
        logic                     wlast;
    } oursring_req_if_w_t;

    typedef struct packed {
        logic [RING_TID_W-1:0]  rid;
        logic [RING_DATA_W-1:0] rdata;
        logic [1:0]             rresp;
    } oursring_resp_if_r_t;

    typedef struct packed {
        logic [RING_TID_W-1:0] bid;
        logic [1:0]            bresp;
    } oursring_resp_if_b_t;
endpackage

module cache_da_mst
    import oursring_pkg::*;
#(
    parameter int RING_ADDR_WIDTH     = 40,
    parameter int RING_DATA_WIDTH     = 64,
    parameter int TID_WIDTH           = 8,
    parameter int WAY_ID_WIDTH        = 2,
    parameter int DATA_CHUNK_ID_WIDTH = 2,
    parameter int BANK_INDEX_WIDTH    = 9,
    parameter logic [RING_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_rw,
    input  logic [2:0]                     cmd_target,
    input  logic [WAY_ID_WIDTH-1:0]        cmd_way,
    input  logic [DATA_CHUNK_ID_WIDTH-1:0] cmd_chunk,
    input  logic [BANK_INDEX_WIDTH-1:0]    cmd_index,
    input  logic [15:0]                    cmd_len,
    input  logic [RING_DATA_WIDTH-1:0]     cmd_wdata,
    output logic                           ring_req_if_arvalid,
    input  logic                           ring_req_if_arready,
    output oursring_req_if_ar_t            ring_req_if_ar,
    output logic                           ring_req_if_awvalid,
    input  logic                           ring_req_if_awready,
    output oursring_req_if_aw_t            ring_req_if_aw,
    output logic                           ring_req_if_wvalid,
    input  logic                           ring_req_if_wready,
    output oursring_req_if_w_t             ring_req_if_w,
    input  logic                           ring_resp_if_rvalid,
    output logic                           ring_resp_if_rready,
    input  oursring_resp_if_r_t            ring_resp_if_r,
    input  logic                           ring_resp_if_bvalid,
    output logic                           ring_resp_if_bready,
    input  oursring_resp_if_b_t            ring_resp_if_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [RING_DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                     rsp_resp,
    output logic                           rsp_last,
    output logic                           busy
);
    localparam int PW = WAY_ID_WIDTH + DATA_CHUNK_ID_WIDTH + BANK_INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, OUT} state_e;

    state_e                       state_q;
    logic                         rw_q;
    logic [2:0]                   target_q;
    logic [PW-1:0]                pos_q;
    logic [15:0]                  remain_q;
    logic [RING_DATA_WIDTH-1:0]   wdata_q;
    logic [TID_WIDTH-1:0]         tid_q;
    logic                         arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
    logic                         rsp_valid_q, rsp_last_q;
    logic [RING_DATA_WIDTH-1:0]   rsp_data_q;
    logic [1:0]                   rsp_resp_q;
    logic [RING_ADDR_WIDTH-1:0]   addr;
    logic                         r_hit, b_hit, issued;
    logic [1:0]                   hit_resp;

`ifdef CACHE_DA_MST_TIMEOUT_EN
    localparam logic IDLE_RDY = 1'b1;
    localparam int   WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
`else
    localparam logic IDLE_RDY = 1'b0;
`endif

    assign addr      = BASE_ADDR | RING_ADDR_WIDTH'({target_q, pos_q, 3'b000});
    // A response on either channel only completes the access when its id matches the live tid.
    assign r_hit     = ring_resp_if_rvalid && rready_q && !rw_q && ring_resp_if_r.rid == tid_q;
    assign b_hit     = ring_resp_if_bvalid && bready_q && rw_q && ring_resp_if_b.bid == tid_q;
    assign hit_resp  = r_hit ? ring_resp_if_r.rresp : ring_resp_if_b.bresp;
    assign issued    = (!arvalid_q || ring_req_if_arready) && (!awvalid_q || ring_req_if_awready) &&
                       (!wvalid_q || ring_req_if_wready);
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign ring_req_if_arvalid = arvalid_q;
    assign ring_req_if_awvalid = awvalid_q;
    assign ring_req_if_wvalid  = wvalid_q;
    assign ring_resp_if_rready = rready_q;
    assign ring_resp_if_bready = bready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_last  = rsp_last_q;

    always_comb begin
        ring_req_if_ar        = '0;
        ring_req_if_ar.arid   = tid_q;
        ring_req_if_ar.araddr = addr;
        ring_req_if_aw        = '0;
        ring_req_if_aw.awid   = tid_q;
        ring_req_if_aw.awaddr = addr;
        ring_req_if_w         = '0;
        ring_req_if_w.wdata   = wdata_q;
        ring_req_if_w.wstrb   = '1;
        ring_req_if_w.wlast   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            target_q    <= '0;
            pos_q       <= '0;
            remain_q    <= '0;
            wdata_q     <= '0;
            tid_q       <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
            rsp_last_q  <= 1'b0;
`ifdef CACHE_DA_MST_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rready_q <= IDLE_RDY;
                    bready_q <= IDLE_RDY;
                    if (cmd_valid) begin
                        rw_q      <= cmd_rw;
                        target_q  <= cmd_target;
                        pos_q     <= {cmd_way, cmd_chunk, cmd_index};
                        remain_q  <= cmd_len;
                        wdata_q   <= cmd_wdata;
                        arvalid_q <= !cmd_rw;
                        awvalid_q <= cmd_rw;
                        wvalid_q  <= cmd_rw;
                        rready_q  <= 1'b0;
                        bready_q  <= 1'b0;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ring_req_if_arready) arvalid_q <= 1'b0;
                    if (ring_req_if_awready) awvalid_q <= 1'b0;
                    if (ring_req_if_wready) wvalid_q <= 1'b0;
                    if (issued) begin
                        rready_q <= 1'b1;
                        bready_q <= 1'b1;
                        state_q  <= WAIT;
`ifdef CACHE_DA_MST_TIMEOUT_EN
                        wdog_q   <= '0;
`endif
                    end
                end
                WAIT: begin
`ifdef CACHE_DA_MST_TIMEOUT_EN
                    wdog_q <= wdog_q + WD_W'(1);
`endif
                    if (r_hit || b_hit) begin
                        rready_q    <= 1'b0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= r_hit ? ring_resp_if_r.rdata : '0;
                        rsp_resp_q  <= hit_resp;
                        rsp_last_q  <= remain_q == 16'd0 || hit_resp != 2'b00;
                        state_q     <= OUT;
                    end
`ifdef CACHE_DA_MST_TIMEOUT_EN
                    else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rready_q    <= 1'b0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_resp_q  <= 2'b10;
                        rsp_last_q  <= 1'b1;
                        state_q     <= OUT;
                    end
`endif
                end
                OUT: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            state_q <= IDLE;
                        end else begin
                            remain_q  <= remain_q - 16'd1;
                            pos_q     <= pos_q + PW'(1);
                            tid_q     <= tid_q + TID_WIDTH'(1);
                            arvalid_q <= !rw_q;
                            awvalid_q <= rw_q;
                            wvalid_q  <= rw_q;
                            state_q   <= ADDR;
                        end
                    end
                end
            endcase
        end
    end
endmodule
